multiplicador_reconstructor: RTL
================================

Name: multiplicador_reconstructor

Overview:
- Iterative signed shift-add multiplier-accumulator that computes Num = Coc*Den + Res.
- It is the inverse of the team's signed divider: it reconstructs the dividend from quotient, divisor and remainder.
- It sits beside the divider in the datapath and in the bench as the result checker. It uses the same Start/Done handshake and the same sign-magnitude handling of operands.

Parameters:
- tamanyo, 32, operand and result width in bits (two's complement); must be >= 4.

Ports:
- CLK  input  1  clock, rising edge.
- RSTa  input  1  reset, asynchronous, active-high.
- Start  input  1  request; sampled only in IDLE.
- Coc  input  tamanyo  signed multiplicand (quotient).
- Den  input  tamanyo  signed multiplier (divisor).
- Res  input  tamanyo  signed addend (remainder).
- Num  output  tamanyo  signed result, low tamanyo bits of Coc*Den+Res; registered.
- Ovf  output  1  result not representable in tamanyo signed bits; registered, valid with Done.
- Busy  output  1  high in MUL and FIN states.
- Done  output  1  one-cycle registered pulse; Num/Ovf valid from this cycle.

Behaviour:
- Reset (RSTa=1, any time, asynchronous):
  - State IDLE; Num=0, Ovf=0, Done=0, Busy=0.
  - All internal registers (ACC, Q, M, CONT, sign bits, Res copy) cleared.
  - Reset mid-operation aborts the operation with no Done.
- States: IDLE, MUL, FIN.
- IDLE:
  - On an edge with Start=1: capture M=|Coc|, Q=|Den| (two's-complement negate if MSB set), SignP=Coc[msb]^Den[msb], ResR=Res.
  - Also ACC (tamanyo bits)=0, CONT=tamanyo-1; next state MUL.
  - Start=0: stay in IDLE; registers hold.
- MUL, one iteration per cycle:
  - {carry,sum} = ACC + (Q[0] ? M : 0), computed in tamanyo+1 bits.
  - {ACC,Q} <= {carry,sum,Q} >> 1, i.e. shift right by one with carry entering the MSB of ACC.
  - If CONT==0, next state FIN; else CONT<=CONT-1.
  - Exactly tamanyo MUL cycles; afterwards {ACC,Q} holds the unsigned 2*tamanyo-bit product.
- FIN, one cycle:
  - P = SignP ? -{ACC,Q} : {ACC,Q}, in 2*tamanyo+1 signed bits.
  - S = P + sign-extended ResR, in 2*tamanyo+1 bits.
  - Register Num <= S[tamanyo-1:0].
  - Ovf <= 1 iff S[2*tamanyo:tamanyo-1] is not all equal (S outside [-2^(tamanyo-1), 2^(tamanyo-1)-1]).
  - Done <= 1; next state IDLE.
- Latency:
  - Start sampled at edge k gives Done high in the cycle following edge k+tamanyo+1, i.e. tamanyo+1 cycles after the sampling edge.
  - Done is low in every other cycle.
- Num and Ovf hold their last values until the next FIN or reset.
- Start while Busy=1 is ignored entirely (not queued). Operand changes while Busy=1 have no effect.
- Start=1 in the cycle Done=1 (state IDLE) is accepted. Back-to-back throughput is one result per tamanyo+2 cycles.
- The most negative operand (-2^(tamanyo-1)) is treated as magnitude 2^(tamanyo-1), unsigned; the product is exact.
- A zero operand gives product 0, so Num=Res and Ovf=0; the sign of zero is irrelevant.
- Busy = (state != IDLE), decoded from the state register.

Test Plan:
- tamanyo=32, Coc=-7, Den=3, Res=-1, Start one cycle -> Done exactly 33 cycles after the sampling edge; Num=-22 (0xFFFFFFEA), Ovf=0.
- Coc=0, Den=0x80000000, Res=5 -> Num=5, Ovf=0. Also Coc=-1, Den=0x80000000, Res=0 -> Num=0x80000000, Ovf=1 (+2^31 not representable).
- Coc=0x00010000, Den=0x00010000, Res=0 -> Num=0, Ovf=1. Coc=0x7FFF, Den=0x7FFF, Res=0x7FFF -> Num=0x3FFF8000, Ovf=0.
- Start pulsed again 10 cycles into an operation with different operands -> ignored; single Done with first result. Start held high in the Done cycle -> second Done 34 cycles after the first.
- RSTa asserted asynchronously mid-MUL (between edges) -> Num, Ovf, Done, Busy go 0 immediately; no Done after release until a new Start.
- Randomised divider cross-check: feed divider outputs (Coc, Res) and its Den -> Num equals the original dividend, Ovf=0, for 1000 random signed pairs with Den!=0.

Source files
------------

// File: rtl/multiplicador_reconstructor.sv
// Iterative signed shift-add multiplier-accumulator: Num = Coc*Den + Res.
// Rebuilds the dividend from the signed divider's quotient, divisor and remainder.
module multiplicador_reconstructor #(
  parameter int tamanyo = 32
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic               Start,
  input  logic [tamanyo-1:0] Coc,
  input  logic [tamanyo-1:0] Den,
  input  logic [tamanyo-1:0] Res,
  output logic [tamanyo-1:0] Num,
  output logic               Ovf,
  output logic               Busy,
  output logic               Done
);

  localparam int CW = $clog2(tamanyo);

  typedef enum logic [1:0] {IDLE, MUL, FIN} estado_t;

  estado_t            estado, estado_sig;
  logic [tamanyo-1:0] acc, q, m, resr;
  logic [CW-1:0]      cont;
  logic               signp;

  logic [tamanyo:0]   suma;
  logic [2*tamanyo:0] prod, p, s;
  logic               ovf_c;

  // The most negative value negates to itself, which read unsigned is the
  // correct magnitude 2^(tamanyo-1).
  function automatic logic [tamanyo-1:0] magnitud(input logic [tamanyo-1:0] v);
    return v[tamanyo-1] ? -v : v;
  endfunction

  assign suma  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
  assign prod  = {1'b0, acc, q};
  assign p     = signp ? -prod : prod;
  assign s     = p + {{(tamanyo+1){resr[tamanyo-1]}}, resr};
  assign ovf_c = !((&s[2*tamanyo:tamanyo-1]) || !(|s[2*tamanyo:tamanyo-1]));
  assign Busy  = (estado != IDLE);

  // NOTE: sequential state is always written with <= so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) estado <= IDLE;
    else      estado <= estado_sig;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    estado_sig = estado;
    case (estado)
      IDLE:    if (Start) estado_sig = MUL;
      MUL:     if (cont == '0) estado_sig = FIN;
      FIN:     estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) begin
      acc   <= '0;
      q     <= '0;
      m     <= '0;
      resr  <= '0;
      cont  <= '0;
      signp <= 1'b0;
      Num   <= '0;
      Ovf   <= 1'b0;
      Done  <= 1'b0;
    end else begin
      Done <= (estado == FIN);
      case (estado)
        IDLE: if (Start) begin
          m     <= magnitud(Coc);
          q     <= magnitud(Den);
          signp <= Coc[tamanyo-1] ^ Den[tamanyo-1];
          resr  <= Res;
          acc   <= '0;
          cont  <= CW'(tamanyo - 1);
        end
        MUL: begin
          // Carry of the partial sum enters the MSB of acc as the pair shifts right.
          {acc, q} <= {suma, q[tamanyo-1:1]};
          if (cont != '0) cont <= cont - 1'b1;
        end
        FIN: begin
          Num <= s[tamanyo-1:0];
          Ovf <= ovf_c;
        end
        default: ;
      endcase
    end
  end

endmodule
